// File: rtl/mux_rr_reg_pkg.sv
// Shared types and helpers for the registered N:1 round-robin multiplexer.
// Holds the select-mode encoding and the modular index helper used by the arbiter.
package mux_rr_reg_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Channel index reached by stepping 'off' places past 'base' on a ring of n channels.
  function automatic int unsigned wrap_idx(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/mux_rr_reg_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping around the ring.
// Purely combinational; the caller owns the pointer register.
module rr_pick
  import mux_rr_reg_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_vld
);

  int unsigned       idx;
  logic [SEL_W-1:0]  sidx;

  // Scan ptr+1 .. ptr+NUM_IN so the channel at ptr itself is considered last.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    sidx      = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx  = wrap_idx(int'(ptr), k, NUM_IN);
      sidx = SEL_W'(idx);
      if (!grant_vld && req[sidx]) begin
        grant     = sidx;
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_reg.sv
// Registered N:1 multiplexer with valid/ready handshake, fixed or round-robin selection.
// One output register; a new word loads whenever the register is empty or being drained.
module mux_rr_reg
  import mux_rr_reg_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rr_en,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    flush,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  input  logic                    out_ready
);

  mode_e             mode;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  rr_grant;
  logic              rr_grant_vld;
  logic              sel_ok;
  logic [SEL_W-1:0]  grant;
  logic              grant_vld;
  logic              load;
  logic [WIDTH-1:0]  grant_data;

  assign mode = mode_e'(rr_en);

  rr_pick #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_rr_pick (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (rr_grant),
    .grant_vld (rr_grant_vld)
  );

  assign sel_ok = (int'(sel) < NUM_IN);

  // Mode mux; reset is folded into load so no channel sees ready while reset is high.
  always_comb begin
    grant      = '0;
    grant_vld  = 1'b0;
    load       = !reset && !flush && (!out_valid || out_ready);
    in_ready   = '0;
    if (mode == MODE_RR) begin
      grant     = rr_grant;
      grant_vld = rr_grant_vld;
    end else begin
      grant     = sel;
      grant_vld = sel_ok && in_valid[sel];
    end
    grant_data = in_data[int'(grant)*WIDTH +: WIDTH];
    if (load && grant_vld) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Output register and pointer; flush only clears valid so data/src stay observable.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= SEL_W'(NUM_IN - 1);
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      if (grant_vld) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_src   <= grant;
        if (mode == MODE_RR) begin
          ptr <= grant;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Self-checking bench for mux_rr_reg: table of handshake vectors plus reset sequences,
// with accepted words queued and compared when they appear on the output register.
module tb_mux_rr_reg;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;
  localparam int NVEC   = 28;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    rr_en;
  logic [SEL_W-1:0]        sel;
  logic                    flush;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_ready;

  typedef struct {
    logic              rst;
    logic              rr;
    logic [SEL_W-1:0]  s;
    logic              fl;
    logic [NUM_IN-1:0] iv;
    logic              ordy;
    logic [NUM_IN-1:0] exp_ready;
    logic              exp_valid;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] src;
  } exp_t;

  vec_t             vecs [NVEC];
  exp_t             sbq [$];
  int               asserts = 0;
  int               failures = 0;
  logic [WIDTH-1:0] exp_data;
  logic [SEL_W-1:0] exp_src;
  logic             exp_valid_next;

  mux_rr_reg #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rr_en     (rr_en),
    .sel       (sel),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] chanData(input int step, input int ch);
    return WIDTH'(32'hCAFE0000 + (step << 8) + ch);
  endfunction

  function automatic vec_t mk(input logic rst, input logic rr, input logic [SEL_W-1:0] s,
                              input logic fl, input logic [NUM_IN-1:0] iv, input logic ordy,
                              input logic [NUM_IN-1:0] er, input logic ev);
    vec_t v;
    v.rst = rst; v.rr = rr; v.s = s; v.fl = fl; v.iv = iv; v.ordy = ordy;
    v.exp_ready = er; v.exp_valid = ev;
    return v;
  endfunction

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check the combinational accept strobe, queue the expected word.
  task automatic applyStimulus(input vec_t v, input int step);
    exp_t e;
    reset     = v.rst;
    rr_en     = v.rr;
    sel       = v.s;
    flush     = v.fl;
    in_valid  = v.iv;
    out_ready = v.ordy;
    for (int ch = 0; ch < NUM_IN; ch++) in_data[ch*WIDTH +: WIDTH] = chanData(step, ch);
    #2;
    checkEq($sformatf("in_ready[%0d]", step), 32'(in_ready), 32'(v.exp_ready));
    for (int ch = 0; ch < NUM_IN; ch++) begin
      if (v.exp_ready[ch]) begin
        e.data = chanData(step, ch);
        e.src  = SEL_W'(ch);
        sbq.push_back(e);
      end
    end
    if (v.rst) begin
      sbq.delete();
      exp_data = '0;
      exp_src  = '0;
    end
    exp_valid_next = v.exp_valid;
  endtask

  // After the edge: pop the word accepted last cycle, then check the whole output register.
  task automatic checkOutput(input int step);
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e        = sbq.pop_front();
      exp_data = e.data;
      exp_src  = e.src;
    end
    checkEq($sformatf("out_valid[%0d]", step), 32'(out_valid), 32'(exp_valid_next));
    checkEq($sformatf("out_data[%0d]", step), 32'(out_data), 32'(exp_data));
    checkEq($sformatf("out_src[%0d]", step), 32'(out_src), 32'(exp_src));
  endtask

  initial begin
    // rst, rr, sel, flush, in_valid, out_ready, expected in_ready, expected out_valid next
    vecs[0]  = mk(0, 0, 2, 0, 4'b0100, 1, 4'b0100, 1);
    vecs[1]  = mk(0, 0, 1, 0, 4'b0100, 1, 4'b0000, 0);
    vecs[2]  = mk(0, 1, 0, 0, 4'b1111, 1, 4'b0001, 1);
    vecs[3]  = mk(0, 1, 0, 0, 4'b1111, 1, 4'b0010, 1);
    vecs[4]  = mk(0, 1, 0, 0, 4'b1111, 1, 4'b0100, 1);
    vecs[5]  = mk(0, 1, 0, 0, 4'b1111, 1, 4'b1000, 1);
    vecs[6]  = mk(0, 1, 0, 0, 4'b1111, 1, 4'b0001, 1);
    vecs[7]  = mk(0, 1, 0, 0, 4'b1010, 1, 4'b0010, 1);
    vecs[8]  = mk(0, 1, 0, 0, 4'b1010, 1, 4'b1000, 1);
    vecs[9]  = mk(0, 1, 0, 0, 4'b1010, 1, 4'b0010, 1);
    vecs[10] = mk(0, 1, 0, 0, 4'b1010, 1, 4'b1000, 1);
    vecs[11] = mk(0, 1, 0, 0, 4'b1111, 1, 4'b0001, 1);
    vecs[12] = mk(0, 1, 0, 0, 4'b1111, 0, 4'b0000, 1);
    vecs[13] = mk(0, 1, 0, 0, 4'b1111, 0, 4'b0000, 1);
    vecs[14] = mk(0, 1, 0, 0, 4'b1111, 0, 4'b0000, 1);
    vecs[15] = mk(0, 1, 0, 0, 4'b1111, 1, 4'b0010, 1);
    vecs[16] = mk(0, 1, 0, 1, 4'b0001, 1, 4'b0000, 0);
    vecs[17] = mk(0, 1, 0, 0, 4'b0001, 1, 4'b0001, 1);
    vecs[18] = mk(0, 1, 0, 0, 4'b0100, 1, 4'b0100, 1);
    vecs[19] = mk(0, 0, 0, 0, 4'b1111, 1, 4'b0001, 1);
    vecs[20] = mk(0, 0, 0, 0, 4'b1111, 1, 4'b0001, 1);
    vecs[21] = mk(0, 1, 0, 0, 4'b1111, 1, 4'b1000, 1);
    vecs[22] = mk(0, 1, 0, 0, 4'b0000, 1, 4'b0000, 0);
    vecs[23] = mk(0, 0, 1, 0, 4'b0010, 1, 4'b0010, 1);
    vecs[24] = mk(0, 0, 1, 0, 4'b0010, 0, 4'b0000, 1);
    vecs[25] = mk(0, 0, 1, 1, 4'b0010, 0, 4'b0000, 0);
    vecs[26] = mk(0, 1, 0, 0, 4'b1111, 0, 4'b0001, 1);
    vecs[27] = mk(0, 1, 0, 0, 4'b1111, 0, 4'b0000, 1);

    exp_data       = '0;
    exp_src        = '0;
    exp_valid_next = 1'b0;

    // Reset held two cycles with every channel requesting.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(mk(1, 1, 0, 0, 4'b1111, 1, 4'b0000, 0), 100 + i);
      checkOutput(100 + i);
    end

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], i);
      checkOutput(i);
    end

    // Reset while a word is held: word discarded, pointer returns so channel 0 wins next.
    applyStimulus(mk(1, 1, 0, 0, 4'b1111, 1, 4'b0000, 0), 200);
    checkOutput(200);
    applyStimulus(mk(0, 1, 0, 0, 4'b1111, 1, 4'b0001, 1), 201);
    checkOutput(201);
    applyStimulus(mk(0, 1, 0, 0, 4'b1111, 1, 4'b0010, 1), 202);
    checkOutput(202);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
